// File: rtl/muldiv_pkg.sv
// Shared types and op decode for the iterative RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add for multiply,
// restoring shift-subtract for divide (quotient bits enter lo from the right).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        shifted = {hi, lo[XLEN-1]};
        // The partial remainder stays below the divisor, so a successful subtract fits in XLEN bits.
        diff    = shifted[XLEN-1:0] - opnd;
        fits    = shifted >= {1'b0, opnd};
        if (div_mode) begin
            hi_next = fits ? diff : shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], fits};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with valid/ready handshakes on both sides.
// Optional MULDIV_FASTPATH_EN skips the iterations for divide-by-zero and signed overflow.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            div_zero_q, div_zero_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;

    op_e             op_in;
    logic            a_neg_in, b_neg_in, b_zero, accept, fast;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (is_div(op_q)),
        .hi       (hi_q),
        .lo       (lo_q),
        .opnd     (opnd_q),
        .hi_next  (step_hi),
        .lo_next  (step_lo)
    );

    always_comb begin
        op_in    = op_e'(op);
        a_neg_in = a_signed(op_in) & a[XLEN-1];
        b_neg_in = b_signed(op_in) & b[XLEN-1];
        a_mag    = a_neg_in ? -a : a;
        b_mag    = b_neg_in ? -b : b;
        b_zero   = (b == '0);
        accept   = in_valid & ~kill;
`ifdef MULDIV_FASTPATH_EN
        fast = is_div(op_in) & (b_zero |
               (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)));
`else
        fast = 1'b0;
`endif
    end

    // Sign fixup; a zero divisor keeps the all-ones quotient un-negated.
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_fix  = (a_neg_q ^ b_neg_q) & ~div_zero_q ? -lo_q : lo_q;
        rem_fix  = a_neg_q ? -hi_q : hi_q;
        if (is_div(op_q)) begin
            fix_res = is_rem(op_q) ? rem_fix : quo_fix;
        end else begin
            fix_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        div_zero_d = div_zero_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = BUSY;
                    op_d       = op_in;
                    a_neg_d    = a_neg_in;
                    b_neg_d    = b_neg_in;
                    div_zero_d = b_zero;
                    cnt_d      = CNT_W'(XLEN);
                    hi_d       = '0;
                    opnd_d     = is_div(op_in) ? b_mag : a_mag;
                    lo_d       = is_div(op_in) ? a_mag : b_mag;
                    // Fast path preloads the accumulator with its final value and goes to fixup.
                    if (fast) begin
                        cnt_d = '0;
                        hi_d  = b_zero ? a_mag : '0;
                        lo_d  = b_zero ? '1 : a_mag;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d  = DONE;
                    result_d = fix_res;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            cnt_q      <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            div_zero_q <= div_zero_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: expected results and latencies are queued at accept
// and compared when out_valid rises. Honours MULDIV_FASTPATH_EN for special-case latency.
module tb_muldiv_iter;

    localparam int XLEN       = 32;
    localparam int NORMAL_LAT = XLEN + 1;
`ifdef MULDIV_FASTPATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = XLEN + 1;
`endif

    logic            clk;
    logic            rst;
    logic            kill;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Independent reference: 64-bit products of extended operands, SV signed division.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ax, by, p;
        logic [31:0] r;
        logic        ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        ax  = ((f == 3'd1) || (f == 3'd2)) ? {{32{x[31]}}, x} : {32'b0, x};
        by  = (f == 3'd1) ? {{32{y[31]}}, y} : {32'b0, y};
        p   = ax * by;
        case (f)
            3'd0:    r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4:    r = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
            3'd5:    r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6:    r = (y == 0) ? x : ovf ? 32'd0 : 32'($signed(x) % $signed(y));
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return SPECIAL_LAT;
        return NORMAL_LAT;
    endfunction

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk);
        op = f; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        e.res = model(f, x, y);
        e.lat = exp_lat(f, x, y);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit saw_ready);
        lat = 0;
        saw_ready = 1'b0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (in_ready) saw_ready = 1'b1;
        end while (!out_valid && lat < 200);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0;
        #2;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || result !== '0)
            $display("[TB] FAIL reset: rdy/vld/busy=%b result=%h, want 100 / 0", {in_ready, out_valid, busy}, result);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  fs[4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] xs[4] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] ys[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] want[4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        int lat;
        bit saw;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fs[i], xs[i], ys[i]);
            wait_done(lat, saw);
            e = sb.pop_front();
            n_checks++;
            if (result !== want[i] || result !== e.res)
                $display("[TB] FAIL mul_%0d: result=%h want %h", i, result, want[i]);
            else n_pass++;
            n_checks++;
            if (lat !== e.lat) $display("[TB] FAIL mul_lat_%0d: latency=%0d want %0d", i, lat, e.lat);
            else n_pass++;
            n_checks++;
            if (saw !== 1'b0) $display("[TB] FAIL mul_in_ready_%0d: in_ready seen 1 while busy, want 0", i);
            else n_pass++;
            take_result();
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'($urandom_range(0, 3)), $urandom, $urandom);
            wait_done(lat, saw);
            e = sb.pop_front();
            n_checks++;
            if (result !== e.res || lat !== e.lat)
                $display("[TB] FAIL mul_rand_%0d: result=%h lat=%0d want %h lat=%0d", i, result, lat, e.res, e.lat);
            else n_pass++;
            take_result();
        end
    endtask

    task automatic test_div();
        logic [2:0]  fs[5] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5};
        logic [31:0] xs[5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000};
        logic [31:0] ys[5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFF};
        logic [31:0] want[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd0};
        int lat;
        bit saw;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(fs[i], xs[i], ys[i]);
            wait_done(lat, saw);
            e = sb.pop_front();
            n_checks++;
            if (result !== want[i] || result !== e.res)
                $display("[TB] FAIL div_%0d: result=%h want %h", i, result, want[i]);
            else n_pass++;
            n_checks++;
            if (lat !== e.lat) $display("[TB] FAIL div_lat_%0d: latency=%0d want %0d", i, lat, e.lat);
            else n_pass++;
            take_result();
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'($urandom_range(4, 7)), $urandom, $urandom >> $urandom_range(0, 28) | 32'd1);
            wait_done(lat, saw);
            e = sb.pop_front();
            n_checks++;
            if (result !== e.res || lat !== e.lat)
                $display("[TB] FAIL div_rand_%0d: result=%h lat=%0d want %h lat=%0d", i, result, lat, e.res, e.lat);
            else n_pass++;
            take_result();
        end
    endtask

    task automatic test_special();
        logic [2:0]  fs[8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] xs[8] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB,
                               32'h8000_0000, 32'h8000_0000};
        logic [31:0] ys[8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] want[8] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
        int lat;
        bit saw;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(fs[i], xs[i], ys[i]);
            wait_done(lat, saw);
            e = sb.pop_front();
            n_checks++;
            if (result !== want[i] || result !== e.res)
                $display("[TB] FAIL special_%0d: result=%h want %h", i, result, want[i]);
            else n_pass++;
            n_checks++;
            if (lat !== SPECIAL_LAT) $display("[TB] FAIL special_lat_%0d: latency=%0d want %0d", i, lat, SPECIAL_LAT);
            else n_pass++;
            take_result();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit saw;
        bit stable;
        exp_t e;
        applyStimulus(3'd0, 32'd123, 32'd456);
        wait_done(lat, saw);
        e = sb.pop_front();
        n_checks++;
        if (result !== 32'd56088 || result !== e.res) $display("[TB] FAIL stall_result: result=%h want %h", result, 32'd56088);
        else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (result !== e.res || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) $display("[TB] FAIL stall_hold: result/in_ready/out_valid changed while stalled, want held");
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else n_pass++;
        op = 3'd5; a = 32'd1000; b = 32'd10; in_valid = 1'b1;
        @(posedge clk);
        e.res = model(3'd5, 32'd1000, 32'd10);
        e.lat = NORMAL_LAT;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) $display("[TB] FAIL b2b_accept: busy=%b in_ready=%b want 1 0", busy, in_ready);
        else n_pass++;
        wait_done(lat, saw);
        e = sb.pop_front();
        n_checks++;
        if (result !== 32'd100 || lat !== e.lat) $display("[TB] FAIL b2b_result: result=%h lat=%0d want %h lat=%0d", result, lat, 32'd100, e.lat);
        else n_pass++;
        take_result();
    endtask

    task automatic test_kill();
        bit   seen;
        exp_t e;
        applyStimulus(3'd0, 32'd99, 32'd77);
        for (int i = 0; i < 10; i++) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("[TB] FAIL kill_idle: in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("[TB] FAIL kill_no_result: out_valid seen 1 after kill, want 0");
        else n_pass++;
        op = 3'd0; a = 32'd3; b = 32'd3; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL kill_vs_valid: busy=%b in_ready=%b want 0 1", busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        bit   seen;
        int   lat;
        bit   saw;
        exp_t e;
        applyStimulus(3'd4, 32'd1000, 32'd3);
        for (int i = 0; i < 5; i++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || result !== '0)
            $display("[TB] FAIL rst_mid: rdy/vld/busy=%b result=%h want 100 / 0", {in_ready, out_valid, busy}, result);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("[TB] FAIL rst_no_result: out_valid seen 1 after reset, want 0");
        else n_pass++;
        applyStimulus(3'd6, 32'd1000, 32'd3);
        wait_done(lat, saw);
        e = sb.pop_front();
        n_checks++;
        if (result !== e.res || lat !== e.lat) $display("[TB] FAIL rst_recover: result=%h lat=%0d want %h lat=%0d", result, lat, e.res, e.lat);
        else n_pass++;
        take_result();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_kill();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
